// File: rtl/spm_bank_scheduler.sv
// Vector scratchpad request scheduler: splits one per-lane request into
// bank-conflict-free passes, coalesces same-address loads, and gathers read data.
module spm_bank_scheduler #(
  parameter int unsigned LANES        = 16,
  parameter int unsigned BANKS        = 16,
  parameter int unsigned ENTRY_ADDR_W = 10,
  parameter int unsigned BYTES        = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_is_store,
  input  logic [LANES-1:0]                 req_lane_mask,
  input  logic [LANES*(ENTRY_ADDR_W+$clog2(BANKS))-1:0] req_address,
  input  logic [LANES*BYTES-1:0]           req_byte_mask,
  input  logic [LANES*8*BYTES-1:0]         req_write_data,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [LANES*8*BYTES-1:0]         resp_read_data,
  output logic [4:0]                       resp_passes,
  output logic [BANKS-1:0]                 bank_enables,
  output logic                             bank_is_store,
  output logic [BANKS*ENTRY_ADDR_W-1:0]    bank_offsets,
  output logic [BANKS*BYTES-1:0]           bank_byte_mask,
  output logic [BANKS*8*BYTES-1:0]         bank_write_data,
  input  logic [BANKS*8*BYTES-1:0]         bank_read_data
);

  localparam int unsigned BANK_W = $clog2(BANKS);
  localparam int unsigned ADDR_W = ENTRY_ADDR_W + BANK_W;
  localparam int unsigned DATA_W = 8 * BYTES;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]                state;
  logic [1:0]                state_next;
  logic                      is_store_q;
  logic [LANES*ADDR_W-1:0]   addr_q;
  logic [LANES*BYTES-1:0]    bm_q;
  logic [LANES*DATA_W-1:0]   wd_q;
  logic [LANES-1:0]          pending;
  logic [LANES-1:0]          capture;
  logic [LANES-1:0]          grant;
  logic [BANKS-1:0]          win_valid;
  logic [LANE_W-1:0]         win_lane  [BANKS];
  logic [ADDR_W-1:0]         lane_addr [LANES];
  logic [BANK_W-1:0]         lane_bank [LANES];
  logic [BYTES-1:0]          lane_bm   [LANES];
  logic [DATA_W-1:0]         lane_wd   [LANES];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Per-lane views of the latched request
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      lane_addr[l] = addr_q[l*ADDR_W +: ADDR_W];
      lane_bank[l] = addr_q[l*ADDR_W +: BANK_W];
      lane_bm[l]   = bm_q[l*BYTES +: BYTES];
      lane_wd[l]   = wd_q[l*DATA_W +: DATA_W];
    end
  end

  // Per-bank winner: lowest-index pending lane (descending scan, last hit wins)
  always_comb begin
    win_valid = '0;
    for (int b = 0; b < int'(BANKS); b++) begin
      win_lane[b] = '0;
      for (int l = int'(LANES) - 1; l >= 0; l--) begin
        if (pending[l] && (lane_bank[l] == BANK_W'(b))) begin
          win_valid[b] = 1'b1;
          win_lane[b]  = LANE_W'(l);
        end
      end
    end
  end

  // A pending lane is granted if it is its bank's winner, or a load sharing the winner's address
  always_comb begin
    grant = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (pending[l]) begin
        if ((win_lane[lane_bank[l]] == LANE_W'(l)) ||
            (!is_store_q && (lane_addr[l] == lane_addr[win_lane[lane_bank[l]]]))) begin
          grant[l] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bank_enables    = '0;
    bank_is_store   = 1'b0;
    bank_offsets    = '0;
    bank_byte_mask  = '0;
    bank_write_data = '0;
    if (state == ISSUE) begin
      bank_enables  = win_valid;
      bank_is_store = is_store_q;
    end
    for (int b = 0; b < int'(BANKS); b++) begin
      bank_offsets[b*ENTRY_ADDR_W +: ENTRY_ADDR_W] = lane_addr[win_lane[b]][ADDR_W-1:BANK_W];
      bank_byte_mask[b*BYTES +: BYTES]             = is_store_q ? lane_bm[win_lane[b]] : '0;
      bank_write_data[b*DATA_W +: DATA_W]          = lane_wd[win_lane[b]];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (req_lane_mask != '0) ? ISSUE : RESP;
      ISSUE:   if ((pending & ~grant) == '0) state_next = DRAIN;
      DRAIN:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latch, pass bookkeeping and read-data capture (one cycle behind issue)
  always_ff @(posedge clock) begin
    if (reset) begin
      is_store_q     <= 1'b0;
      addr_q         <= '0;
      bm_q           <= '0;
      wd_q           <= '0;
      pending        <= '0;
      capture        <= '0;
      resp_read_data <= '0;
      resp_passes    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_store_q     <= req_is_store;
            addr_q         <= req_address;
            bm_q           <= req_byte_mask;
            wd_q           <= req_write_data;
            pending        <= req_lane_mask;
            capture        <= '0;
            resp_read_data <= '0;
            resp_passes    <= '0;
          end
        end
        ISSUE: begin
          pending     <= pending & ~grant;
          capture     <= grant;
          resp_passes <= resp_passes + 5'd1;
        end
        DRAIN:   capture <= '0;
        default: capture <= '0;
      endcase
      if (((state == ISSUE) || (state == DRAIN)) && !is_store_q) begin
        for (int l = 0; l < int'(LANES); l++) begin
          if (capture[l]) begin
            resp_read_data[l*DATA_W +: DATA_W] <= bank_read_data[int'(lane_bank[l])*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: doc/spm_bank_scheduler.md
Name: spm_bank_scheduler

Overview:
- Sequences one vector scratchpad request (one word address per lane) onto the multi-bank SPM array.
- Detects bank conflicts and splits the request into conflict-free passes. Coalesces identical-address loads into one pass.
- Collects per-lane read data and returns a single response.
- Sits between the SPM front end (address/lane decode) and the banked memory array.

Parameters:
LANES, 16, number of vector lanes per request
BANKS, 16, number of memory banks; power of two
ENTRY_ADDR_W, 10, per-bank entry offset width
BYTES, 4, bytes per bank entry; DATA_W = 8*BYTES
BANK_W, log2(BANKS), derived; lane address width ADDR_W = ENTRY_ADDR_W + BANK_W

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  scheduler can accept a request
req_is_store  in  1  1 = store, 0 = load
req_lane_mask  in  LANES  active lanes
req_address  in  LANES*ADDR_W  per-lane word address; low BANK_W bits = bank, upper bits = entry offset
req_byte_mask  in  LANES*BYTES  per-lane store byte enables
req_write_data  in  LANES*DATA_W  per-lane store data
resp_valid  out  1  response ready
resp_ready  in  1  consumer accepts the response
resp_read_data  out  LANES*DATA_W  per-lane load data; 0 for inactive lanes and for stores
resp_passes  out  5  number of issue passes used
bank_enables  out  BANKS  per-bank access enable
bank_is_store  out  1  store qualifier to the array
bank_offsets  out  BANKS*ENTRY_ADDR_W  per-bank entry offset
bank_byte_mask  out  BANKS*BYTES  per-bank byte mask
bank_write_data  out  BANKS*DATA_W  per-bank write data
bank_read_data  in  BANKS*DATA_W  registered array output, valid one cycle after enable

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, RESP. Reset returns to IDLE.
- Reset values: req_ready=1, resp_valid=0, bank_enables=0, bank_is_store=0, resp_read_data=0, resp_passes=0, pending/capture masks=0.
- IDLE: req_ready=1. When req_valid=1, latch all request fields, set pending=req_lane_mask, clear result registers and resp_passes.
  - Next state is ISSUE if the mask is nonzero; otherwise RESP, with resp_passes=0.
- ISSUE, each cycle, for each bank b:
  - Winner = lowest-index pending lane whose bank field equals b.
  - Drive bank_enables[b]=1 with the winner's offset, byte mask and write data. bank_byte_mask is 0 for loads.
  - Loads only: every pending lane with the same full address as the winner is also granted in this pass.
  - Stores are never coalesced. Ascending lane order therefore leaves the highest lane's data in memory for same-address stores.
  - Granted lanes clear from pending. The granted mask is registered into capture, together with each lane's bank index. resp_passes increments.
  - When pending becomes 0 this cycle, next state is DRAIN.
- Capture: in the cycle after a pass issues, each lane set in capture loads bank_read_data[its bank] into its result register, loads only. This overlaps with the next ISSUE pass.
- DRAIN: one cycle with no bank_enables; performs the final capture, then moves to RESP. Stores also take the DRAIN cycle, so latency is uniform.
- RESP: resp_valid=1 and the response fields are held stable until resp_ready=1, then return to IDLE. req_ready=0 in every state except IDLE.
- Latency: a conflict-free request accepted at edge 0 issues in cycle 1, drains in cycle 2 and asserts resp_valid in cycle 3. In general resp_valid asserts at cycle passes+2.
- Passes = max over banks of the number of distinct addresses (loads) or lanes (stores) mapped to that bank; range 1..LANES.
- Reset mid-operation: abort immediately. Next cycle bank_enables=0 and the FSM is in IDLE; no partial response is produced.
- Outside ISSUE, bank_enables is 0. bank_offsets, bank_byte_mask and bank_write_data are don't-care when the matching enable is 0.

Test Plan:
- Load, all 16 lanes, lane i address = i (distinct banks) -> one pass, all 16 bank_enables set, resp_valid 3 cycles after accept, lane i data = bank i contents, resp_passes=1.
- Load, all lanes address 0x20 (bank 0, offset 2) -> one pass (coalesced), only bank_enables[0], every lane returns the entry at offset 2, resp_passes=1.
- Store, all lanes address 0x20, lane i data = i -> 16 passes, one enable per cycle, final memory word = 15, resp_passes=16, resp_valid at cycle 18.
- Load, lanes 0..3 addresses 0x00, 0x10, 0x20, 0x01 -> bank 0 takes 3 passes; lane 3 issues in pass 1 alongside lane 0; resp_passes=3; correct per-lane data.
- Empty lane mask -> RESP next cycle, no enables, all data 0, resp_passes=0. Then hold resp_ready=0 for 5 cycles -> response stays stable and req_ready=0.
- Reset asserted during pass 2 of a 4-pass store -> bank_enables=0 on the next cycle, FSM in IDLE, req_ready=1, no resp_valid.
